// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, imem read issue,
// in-order instruction buffer and redirect/flush handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          BUF_DEPTH       = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH);

  logic [31:0]   r_pc;
  logic [31:0]   r_rsp_pc;
  logic [OW-1:0] r_out;
  logic [OW-1:0] r_drop;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [31:0]   r_pcq [BUF_DEPTH];
  logic [31:0]   r_iq  [BUF_DEPTH];

  logic          w_pop;
  logic          w_fire;
  logic          w_push;
  logic          w_drop;
  logic [31:0]   w_occ;
  logic [31:0]   w_redir_pc;
  logic          w_unused;

  assign w_unused   = ^redirect_pc[1:0];
  assign w_redir_pc = {redirect_pc[31:2], 2'b00};

  assign if_valid = !rst && (r_cnt != '0) && !redirect_valid;
  assign w_pop    = if_valid && if_ready;

  // Slots already promised: in-flight requests plus buffered entries.
  assign w_occ = 32'(r_out) + 32'(r_cnt) - {31'd0, w_pop};

  assign imem_req_valid = !rst && !redirect_valid &&
                          (r_out < OW'(MAX_OUTSTANDING)) &&
                          (w_occ < 32'(BUF_DEPTH));
  assign imem_req_addr  = r_pc;
  assign w_fire         = imem_req_valid && imem_req_ready;

  assign w_drop = imem_rsp_valid && (r_drop != '0);
  assign w_push = !rst && imem_rsp_valid && (r_drop == '0) &&
                  !redirect_valid;

  assign if_pc    = (r_cnt != '0) ? r_pcq[r_rp] : '0;
  assign if_instr = (r_cnt != '0) ? r_iq[r_rp]  : '0;

  // PC, outstanding/drop bookkeeping and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_rsp_pc <= RESET_PC;
      r_out    <= '0;
      r_drop   <= '0;
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
    end else if (redirect_valid) begin
      r_pc     <= w_redir_pc;
      r_rsp_pc <= w_redir_pc;
      r_cnt    <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_out    <= r_out - OW'(imem_rsp_valid);
      r_drop   <= r_out - OW'(imem_rsp_valid);
    end else begin
      if (w_fire)
        r_pc <= r_pc + 32'd4;
      r_out <= r_out + OW'(w_fire) - OW'(imem_rsp_valid);
      if (w_drop)
        r_drop <= r_drop - OW'(1);
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + 32'd4;
        r_wp     <= r_wp + PW'(1);
      end
      if (w_pop)
        r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Buffer storage; contents only meaningful below r_cnt.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pcq[r_wp] <= r_rsp_pc;
      r_iq[r_wp]  <= imem_rsp_data;
    end
  end

  // Issue throttling must make buffer overflow unreachable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && !w_pop && r_cnt == CW'(BUF_DEPTH)));
      assert (!(imem_rsp_valid && r_out == '0));
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-order imem model
// and a stream-level reference of the expected {pc, instr} sequence.
module tb_fetch_unit;

  localparam logic [31:0] K       = 32'hA5A5_0000;
  localparam int          MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          due;
  } req_t;

  req_t        mq[$];
  logic [31:0] eq[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [31:0] exp_addr;
  int          fires = 0;
  int          pops  = 0;
  logic [31:0] mon_last_pc;
  logic        last_fire, last_ifv, last_reqv;
  logic [31:0] last_addr, last_pc;
  logic        rst_prev = 1'b0;
  logic        hold_chk = 1'b0;
  logic [31:0] hold_addr;

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", nm, act, req);
    end
  endtask

  // Monitor: every accepted instruction must match the next expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && if_valid === 1'b1 && if_ready === 1'b1) begin
        if (eq.size() == 0) begin
          check("unexpected_pop", if_pc, 32'hFFFF_FFFF ^ if_pc);
        end else begin
          logic [31:0] p;
          p = eq.pop_front();
          check("if_pc", if_pc, p);
          check("if_instr", if_instr, p ^ K);
        end
        mon_last_pc = if_pc;
        pops++;
      end
    end
  end

  // One clock cycle: drive imem response, sample at edge, update model.
  task automatic cycle_go();
    logic rsp, fire;
    int   due;
    rsp = 1'b0;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) rsp = 1'b1;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? (mq[0].a ^ K) : 32'd0;
    #3;
    fire      = imem_req_valid && imem_req_ready;
    last_fire = fire;
    last_addr = imem_req_addr;
    last_ifv  = if_valid;
    last_reqv = imem_req_valid;
    last_pc   = if_pc;
    if (hold_chk) check("addr_hold", imem_req_addr, hold_addr);
    hold_chk  = !rst && !fire && !redirect_valid;
    hold_addr = imem_req_addr;
    if (rst) begin
      if (rst_prev) begin
        check("rst_reqv", {31'd0, imem_req_valid}, 32'd0);
        check("rst_ifv", {31'd0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_addr", imem_req_addr, 32'd0);
      end
      mq.delete();
      eq.delete();
      exp_addr = 32'd0;
    end else begin
      if (redirect_valid) begin
        check("redir_reqv", {31'd0, imem_req_valid}, 32'd0);
        check("redir_ifv", {31'd0, if_valid}, 32'd0);
      end
      if (fire) begin
        check("req_addr", imem_req_addr, exp_addr);
        check("max_out", {31'd0, mq.size() < MAX_OUT}, 32'd1);
      end
      if (rsp) void'(mq.pop_front());
      if (fire) begin
        due = cyc + $urandom_range(lat_hi, lat_lo);
        if (mq.size() > 0 && mq[$].due >= due) due = mq[$].due + 1;
        mq.push_back('{a: imem_req_addr, due: due});
        eq.push_back(imem_req_addr);
        exp_addr = exp_addr + 32'd4;
        fires++;
      end
      if (redirect_valid) begin
        eq.delete();
        exp_addr = {redirect_pc[31:2], 2'b00};
      end
    end
    rst_prev = rst;
    @(negedge clk);
    cyc++;
  endtask

  task automatic next_pop(string nm, logic [31:0] want);
    int p0;
    p0 = pops;
    for (int i = 0; i < 40 && pops == p0; i++) cycle_go();
    total++;
    if (pops == p0) begin
      bad++;
      $display("FAIL %s_timeout act=none req=%h", nm, want);
    end else if (mon_last_pc !== want) begin
      bad++;
      $display("FAIL %s act=%h req=%h", nm, mon_last_pc, want);
    end
  endtask

  task automatic wait_out(int n);
    for (int i = 0; i < 30 && mq.size() != n; i++) cycle_go();
    check("reach_outstanding", mq.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    cycle_go();
    cycle_go();
    rst = 1'b0;
  endtask

  initial begin
    int f0;
    rst = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    exp_addr       = 32'd0;
    @(negedge clk);

    // Reset, first fire, 2-cycle latency to if_valid, then full rate.
    do_reset();
    cycle_go();
    check("first_fire", {31'd0, last_fire}, 32'd1);
    check("first_addr", last_addr, 32'd0);
    cycle_go();
    check("ifv_c1", {31'd0, last_ifv}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle_go();
      check("stream_ifv", {31'd0, last_ifv}, 32'd1);
      check("stream_pc", last_pc, 32'(i * 4));
    end

    // Decode stalled: buffer fills with exactly four entries.
    do_reset();
    if_ready = 1'b0;
    f0 = fires;
    for (int i = 0; i < 12; i++) cycle_go();
    check("stall_fires", fires - f0, 4);
    check("stall_reqv", {31'd0, last_reqv}, 32'd0);
    if_ready = 1'b1;
    next_pop("release0", 32'h0);
    next_pop("release1", 32'h4);
    next_pop("release2", 32'h8);
    next_pop("release3", 32'hC);

    // Redirect with two slow responses in flight.
    lat_lo = 3;
    lat_hi = 3;
    wait_out(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    cycle_go();
    redirect_valid = 1'b0;
    cycle_go();
    check("empty_after_redir", {31'd0, last_ifv}, 32'd0);
    next_pop("redir100", 32'h100);
    next_pop("redir104", 32'h104);

    // Redirect colliding with a response and a would-be pop.
    lat_lo = 1;
    lat_hi = 1;
    for (int i = 0; i < 6; i++) cycle_go();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0202;
    cycle_go();
    redirect_valid = 1'b0;
    next_pop("redir200", 32'h200);
    next_pop("redir204", 32'h204);

    // imem not ready: address holds at 0x40.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    imem_req_ready = 1'b0;
    cycle_go();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle_go();
    check("nr_fire", {31'd0, last_fire}, 32'd0);
    check("nr_addr", last_addr, 32'h40);
    imem_req_ready = 1'b1;
    cycle_go();
    check("nr_rel_fire", {31'd0, last_fire}, 32'd1);
    check("nr_rel_addr", last_addr, 32'h40);
    cycle_go();
    check("nr_next_addr", last_addr, 32'h44);

    // PC wrap and reset with requests outstanding.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle_go();
    redirect_valid = 1'b0;
    next_pop("wrap_hi", 32'hFFFF_FFFC);
    next_pop("wrap_lo", 32'h0);
    lat_lo = 2;
    lat_hi = 2;
    wait_out(2);
    do_reset();
    cycle_go();
    check("post_rst_fire", {31'd0, last_fire}, 32'd1);
    check("post_rst_addr", last_addr, 32'd0);

    // Randomized traffic.
    lat_lo = 1;
    lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      rst            = ($urandom_range(199, 0) == 0);
      redirect_valid = !rst && ($urandom_range(19, 0) == 0);
      redirect_pc    = $urandom;
      if ($urandom_range(1, 0) == 1) redirect_pc[31:8] = 24'hFFFFFF;
      imem_req_ready = ($urandom_range(3, 0) != 0);
      if_ready       = ($urandom_range(2, 0) != 0);
      cycle_go();
    end

    // Drain: stop fetching, let everything in flight be delivered.
    rst            = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    if_ready       = 1'b1;
    for (int i = 0; i < 60 && (eq.size() != 0 || mq.size() != 0); i++)
      cycle_go();
    check("drain_left", eq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
